// File: rtl/ltssm_substate_sequencer.sv
// LTSSM substate sequencer: issues substates to the RX/TX LTSSMs,
// collects their finish codes and steps the link towards L0.
module ltssm_substate_sequencer #(
  parameter int unsigned WATCHDOG_CYCLES = 200000,
  parameter int unsigned WD_W            = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_finish,
  input  logic [3:0] rx_exit_to,
  input  logic       tx_finish,
  input  logic [3:0] tx_exit_to,
  input  logic [4:0] lanes_detected,
  input  logic       force_detect,
  input  logic       l0_exit_req,
  output logic [3:0] substate,
  output logic       link_up,
  output logic [4:0] num_lanes,
  output logic [7:0] retrain_count,
  output logic       seq_error
);

  typedef enum logic [1:0] {
    S_ISSUE,
    S_WAIT,
    S_RESOLVE,
    S_L0
  } fsm_e;

  localparam logic [3:0] SUB_DQ  = 4'd0;
  localparam logic [3:0] SUB_DA  = 4'd1;
  localparam logic [3:0] SUB_PA  = 4'd2;
  localparam logic [3:0] SUB_L0  = 4'd10;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

  fsm_e            fsm_q, fsm_d;
  logic [3:0]      sub_q, sub_d;
  logic            link_q, link_d;
  logic [4:0]      lanes_q, lanes_d;
  logic [7:0]      retr_q, retr_d;
  logic            err_q, err_d;
  logic            rxd_q, rxd_d;
  logic            txd_q, txd_d;
  logic [3:0]      rxc_q, rxc_d;
  logic [3:0]      txc_q, txc_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic rx_seen;
  logic tx_seen;
  logic forced;

  assign rx_seen = rxd_q | rx_finish;
  assign tx_seen = txd_q | tx_finish;
  assign forced  = force_detect && (fsm_q != S_ISSUE) && (sub_q != SUB_DQ);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q   <= S_ISSUE;
      sub_q   <= SUB_DQ;
      link_q  <= 1'b0;
      lanes_q <= '0;
      retr_q  <= '0;
      err_q   <= 1'b0;
      rxd_q   <= 1'b0;
      txd_q   <= 1'b0;
      rxc_q   <= '0;
      txc_q   <= '0;
      wd_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      sub_q   <= sub_d;
      link_q  <= link_d;
      lanes_q <= lanes_d;
      retr_q  <= retr_d;
      err_q   <= err_d;
      rxd_q   <= rxd_d;
      txd_q   <= txd_d;
      rxc_q   <= rxc_d;
      txc_q   <= txc_d;
      wd_q    <= wd_d;
    end
  end

  // Next FSM state, next substate, error pulse and lane latch
  always_comb begin
    fsm_d   = fsm_q;
    sub_d   = sub_q;
    err_d   = 1'b0;
    lanes_d = lanes_q;
    unique case (fsm_q)
      S_ISSUE: begin
        fsm_d = (sub_q == SUB_L0) ? S_L0 : S_WAIT;
      end
      S_WAIT: begin
        if (rx_seen && tx_seen) begin
          fsm_d = S_RESOLVE;
        end else if (wd_q == WD_LAST) begin
          fsm_d = S_ISSUE;
          sub_d = SUB_DQ;
          err_d = 1'b1;
        end
      end
      S_RESOLVE: begin
        fsm_d = S_ISSUE;
        if (sub_q == SUB_DQ) begin
          sub_d = SUB_DA;
        end else if (rxc_q == SUB_DQ || txc_q == SUB_DQ) begin
          sub_d = SUB_DQ;
        end else if (rxc_q != txc_q ||
                     rxc_q != sub_q + 4'd1 ||
                     rxc_q > SUB_L0) begin
          sub_d = SUB_DQ;
          err_d = 1'b1;
        end else begin
          sub_d = rxc_q;
          if (sub_q == SUB_DA && rxc_q == SUB_PA) begin
            lanes_d = lanes_detected;
          end
        end
      end
      S_L0: begin
        if (l0_exit_req) begin
          fsm_d = S_ISSUE;
          sub_d = SUB_DQ;
        end
      end
      default: begin
        fsm_d = S_ISSUE;
      end
    endcase
    if (forced) begin
      fsm_d   = S_ISSUE;
      sub_d   = SUB_DQ;
      err_d   = 1'b0;
      lanes_d = lanes_q;
    end
  end

  // Finish flags, exit codes, watchdog and retrain counter
  always_comb begin
    rxd_d  = rxd_q;
    txd_d  = txd_q;
    rxc_d  = rxc_q;
    txc_d  = txc_q;
    wd_d   = wd_q;
    retr_d = retr_q;
    if (fsm_q == S_ISSUE) begin
      rxd_d = 1'b0;
      txd_d = 1'b0;
      wd_d  = '0;
    end else if (fsm_q == S_WAIT) begin
      wd_d = wd_q + 1'b1;
      if (rx_finish && !rxd_q) begin
        rxd_d = 1'b1;
        rxc_d = rx_exit_to;
      end
      if (tx_finish && !txd_q) begin
        txd_d = 1'b1;
        txc_d = tx_exit_to;
      end
    end
    if (fsm_d == S_ISSUE && fsm_q != S_ISSUE) begin
      rxd_d = 1'b0;
      txd_d = 1'b0;
    end
    if (sub_q != SUB_DQ && sub_d == SUB_DQ && retr_q != 8'hFF) begin
      retr_d = retr_q + 8'd1;
    end
  end

  // Link-up tracks the substate being loaded
  always_comb begin
    link_d = (sub_d == SUB_L0);
  end

  assign substate      = sub_q;
  assign link_up       = link_q;
  assign num_lanes     = lanes_q;
  assign retrain_count = retr_q;
  assign seq_error     = err_q;

endmodule

// File: tb/tb_ltssm_substate_sequencer.sv
// Directed bench for ltssm_substate_sequencer with a short
// watchdog so that the abort path is reachable quickly.
module tb_ltssm_substate_sequencer;

  logic       clk;
  logic       reset;
  logic       rx_finish;
  logic [3:0] rx_exit_to;
  logic       tx_finish;
  logic [3:0] tx_exit_to;
  logic [4:0] lanes_detected;
  logic       force_detect;
  logic       l0_exit_req;
  logic [3:0] substate;
  logic       link_up;
  logic [4:0] num_lanes;
  logic [7:0] retrain_count;
  logic       seq_error;

  int tests = 0;
  int fails = 0;

  ltssm_substate_sequencer #(
    .WATCHDOG_CYCLES(16),
    .WD_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_finish(rx_finish),
    .rx_exit_to(rx_exit_to),
    .tx_finish(tx_finish),
    .tx_exit_to(tx_exit_to),
    .lanes_detected(lanes_detected),
    .force_detect(force_detect),
    .l0_exit_req(l0_exit_req),
    .substate(substate),
    .link_up(link_up),
    .num_lanes(num_lanes),
    .retrain_count(retrain_count),
    .seq_error(seq_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called while in WAIT: both sides finish in the same cycle.
  task automatic resolve(input logic [3:0] rc, input logic [3:0] tc);
    rx_finish  = 1'b1;
    rx_exit_to = rc;
    tx_finish  = 1'b1;
    tx_exit_to = tc;
    tick();
    rx_finish = 1'b0;
    tx_finish = 1'b0;
    tick();
  endtask

  // Called while in ISSUE: one full substate step.
  task automatic adv(input logic [3:0] rc, input logic [3:0] tc);
    tick();
    resolve(rc, tc);
  endtask

  task automatic goto_from0(input int n);
    for (int k = 0; k < n; k++) adv(4'(k + 1), 4'(k + 1));
  endtask

  initial begin
    reset          = 1'b0;
    rx_finish      = 1'b0;
    rx_exit_to     = '0;
    tx_finish      = 1'b0;
    tx_exit_to     = '0;
    lanes_detected = 5'd4;
    force_detect   = 1'b0;
    l0_exit_req    = 1'b0;
    tick();
    tick();
    chk("rst_sub", 32'(substate), 0);
    chk("rst_link", 32'(link_up), 0);
    chk("rst_lanes", 32'(num_lanes), 0);
    chk("rst_retr", 32'(retrain_count), 0);
    chk("rst_err", 32'(seq_error), 0);
    reset = 1'b1;

    // T1: walk detectQuiet .. L0
    for (int s = 0; s < 10; s++) begin
      adv(4'(s + 1), 4'(s + 1));
      chk("t1_sub", 32'(substate), 32'(s + 1));
      chk("t1_err", 32'(seq_error), 0);
    end
    chk("t1_link", 32'(link_up), 1);
    chk("t1_lanes", 32'(num_lanes), 4);
    chk("t1_retr", 32'(retrain_count), 0);

    // T5: force_detect in L0
    tick();
    tick();
    tick();
    chk("l0_hold", 32'(substate), 10);
    force_detect = 1'b1;
    tick();
    force_detect = 1'b0;
    chk("force_sub", 32'(substate), 0);
    chk("force_link", 32'(link_up), 0);
    chk("force_retr", 32'(retrain_count), 1);
    chk("force_err", 32'(seq_error), 0);

    // T5: l0_exit_req
    goto_from0(10);
    tick();
    l0_exit_req = 1'b1;
    tick();
    l0_exit_req = 1'b0;
    chk("l0x_sub", 32'(substate), 0);
    chk("l0x_link", 32'(link_up), 0);
    chk("l0x_retr", 32'(retrain_count), 2);

    // T5: force_detect ignored at detectQuiet
    force_detect = 1'b1;
    tick();
    tick();
    chk("fq_sub", 32'(substate), 0);
    chk("fq_retr", 32'(retrain_count), 2);
    force_detect = 1'b0;
    resolve(4'd1, 4'd1);
    chk("fq_next", 32'(substate), 1);

    // T2: RX exit to 0
    adv(4'd2, 4'd2);
    chk("t2_pre", 32'(substate), 2);
    adv(4'd0, 4'd3);
    chk("t2_sub", 32'(substate), 0);
    chk("t2_retr", 32'(retrain_count), 3);
    chk("t2_err", 32'(seq_error), 0);

    // T3: code mismatch
    goto_from0(4);
    chk("t3_pre", 32'(substate), 4);
    adv(4'd5, 4'd6);
    chk("t3_err", 32'(seq_error), 1);
    chk("t3_sub", 32'(substate), 0);
    chk("t3_retr", 32'(retrain_count), 4);
    tick();
    chk("t3_errpulse", 32'(seq_error), 0);
    resolve(4'd1, 4'd1);

    // T4: watchdog with TX silent
    adv(4'd2, 4'd2);
    adv(4'd3, 4'd3);
    chk("t4_pre", 32'(substate), 3);
    tick();
    rx_finish  = 1'b1;
    rx_exit_to = 4'd4;
    tick();
    rx_finish = 1'b0;
    repeat (14) tick();
    chk("t4_wait_sub", 32'(substate), 3);
    chk("t4_wait_err", 32'(seq_error), 0);
    tick();
    chk("t4_sub", 32'(substate), 0);
    chk("t4_err", 32'(seq_error), 1);
    chk("t4_retr", 32'(retrain_count), 5);
    tick();
    chk("t4_errpulse", 32'(seq_error), 0);
    resolve(4'd1, 4'd1);

    // T6: finish in ISSUE ignored, split finishes, lane latch
    lanes_detected = 5'd8;
    rx_finish  = 1'b1;
    rx_exit_to = 4'd2;
    tick();
    rx_finish  = 1'b0;
    tx_finish  = 1'b1;
    tx_exit_to = 4'd2;
    tick();
    tx_finish = 1'b0;
    tick();
    tick();
    chk("t6_issue_ign", 32'(substate), 1);
    rx_finish = 1'b1;
    tick();
    rx_finish = 1'b0;
    tick();
    chk("t6_split", 32'(substate), 2);
    chk("t6_lanes", 32'(num_lanes), 8);
    lanes_detected = 5'd16;
    adv(4'd3, 4'd3);
    chk("t6_lanes_hold", 32'(num_lanes), 8);

    // Second RX pulse before RESOLVE keeps first code
    tick();
    rx_finish  = 1'b1;
    rx_exit_to = 4'd4;
    tick();
    rx_exit_to = 4'd0;
    tx_finish  = 1'b1;
    tx_exit_to = 4'd4;
    tick();
    rx_finish = 1'b0;
    tx_finish = 1'b0;
    tick();
    chk("dup_pulse", 32'(substate), 4);

    // T6: reset mid-WAIT
    tick();
    reset = 1'b0;
    #1;
    chk("rstw_sub", 32'(substate), 0);
    chk("rstw_retr", 32'(retrain_count), 0);
    chk("rstw_lanes", 32'(num_lanes), 0);
    tick();
    reset = 1'b1;
    lanes_detected = 5'd2;
    goto_from0(10);
    chk("re_link", 32'(link_up), 1);
    chk("re_lanes", 32'(num_lanes), 2);
    tick();
    reset = 1'b0;
    #1;
    chk("rstl0_link", 32'(link_up), 0);
    chk("rstl0_sub", 32'(substate), 0);
    tick();
    reset = 1'b1;

    // T5: retrain_count saturation
    for (int i = 1; i <= 300; i++) begin
      adv(4'd1, 4'd1);
      tick();
      force_detect = 1'b1;
      tick();
      force_detect = 1'b0;
      if (i == 254) chk("sat_254", 32'(retrain_count), 254);
      if (i == 255) chk("sat_255", 32'(retrain_count), 255);
    end
    chk("sat_300", 32'(retrain_count), 255);
    chk("sat_sub", 32'(substate), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
